// File: rtl/key_sched_pkg.sv
// key_sched_pkg: shared AES key-schedule encodings, Nk/Nr lookups and the Rcon table.
package key_sched_pkg;

    typedef enum logic [1:0] {
        MODE_128  = 2'b00,
        MODE_192  = 2'b01,
        MODE_256  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_e;

    localparam int MAX_WORDS = 60;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;
    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    // Indexed by round number i/Nk; entry 0 and 11..15 are never used
    localparam logic [7:0] RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    function automatic logic [3:0] nk_of(input logic [1:0] m);
        return (m == MODE_192) ? NK_192 : (m == MODE_256) ? NK_256 : NK_128;
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] m);
        return (m == MODE_192) ? NR_192 : (m == MODE_256) ? NR_256 : NR_128;
    endfunction

endpackage

// File: rtl/key_expand_iter_sbox.sv
// key_expand_iter_sbox: AES forward S-box, one byte in, one byte out.
module key_expand_iter_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y_o = SBOX[{a_i, 3'b000} +: 8];

endmodule

// File: rtl/key_expand_iter.sv
// key_expand_iter: iterative AES-128/192/256 key schedule, one word per cycle,
// into a 60-word buffer read back as 128-bit round keys.
module key_expand_iter
    import key_sched_pkg::*;
#(
    parameter bit SUPPORT_256 = 1'b1,
    parameter bit RD_REG      = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [255:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         key_valid,
    output logic [3:0]   num_rounds,
    input  logic [3:0]   rd_round,
    output logic [127:0] rd_key
);

    state_e      state_q, state_d;
    logic [5:0]  i_q, i_d;
    logic [2:0]  kmod_q, kmod_d;
    logic [3:0]  rnd_q, rnd_d;
    logic [3:0]  nk_q, nk_d;
    logic [3:0]  nr_q, nr_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] buf_q [MAX_WORDS];

    logic        mode_ok, accept, wrap;
    logic [3:0]  nk_load;
    logic [5:0]  last_idx, rb;
    logic [31:0] w_prev, w_old, sub_in, sub, t, w_new;
    logic [127:0] rd_comb;

    assign nk_load  = nk_of(mode);
    assign mode_ok  = (mode == MODE_128) || (mode == MODE_192) || (SUPPORT_256 && mode == MODE_256);
    assign accept   = (state_q == IDLE) && start && mode_ok;
    assign last_idx = {nr_q, 2'b00} + 6'd3;
    assign wrap     = ({1'b0, kmod_q} == nk_q - 4'd1);

    // kmod_q tracks i mod Nk and rnd_q tracks i/Nk, so no divider is needed
    assign w_prev = buf_q[i_q - 6'd1];
    assign w_old  = buf_q[i_q - {2'b00, nk_q}];
    assign sub_in = (kmod_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    assign t      = (kmod_q == 3'd0) ? sub ^ {RCON[rnd_q], 24'h0} :
                    (nk_q == NK_256 && kmod_q == 3'd4) ? sub : w_prev;
    assign w_new  = w_old ^ t;

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        key_expand_iter_sbox u_sbox (.a_i(sub_in[8*b +: 8]), .y_o(sub[8*b +: 8]));
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        kmod_d  = kmod_q;
        rnd_d   = rnd_q;
        nk_d    = nk_q;
        nr_d    = nr_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (state_q == IDLE) begin
            err_d = start && !mode_ok;
            if (accept) begin
                state_d = EXPAND;
                nk_d    = nk_load;
                nr_d    = nr_of(mode);
                i_d     = {2'b00, nk_load};
                kmod_d  = 3'd0;
                rnd_d   = 4'd1;
                valid_d = 1'b0;
            end
        end else if (i_q == last_idx) begin
            state_d = IDLE;
            valid_d = 1'b1;
            done_d  = 1'b1;
        end else begin
            i_d    = i_q + 6'd1;
            kmod_d = wrap ? 3'd0 : kmod_q + 3'd1;
            rnd_d  = wrap ? rnd_q + 4'd1 : rnd_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q     <= '0;
            kmod_q  <= '0;
            rnd_q   <= '0;
            nk_q    <= '0;
            nr_q    <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            kmod_q  <= kmod_d;
            rnd_q   <= rnd_d;
            nk_q    <= nk_d;
            nr_q    <= nr_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Buffer is not reset; key_valid masks stale contents on the read port
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) < nk_load) buf_q[k] <= key_in[255 - 32*k -: 32];
            end
        end else if (state_q == EXPAND) begin
            buf_q[i_q] <= w_new;
        end
    end

    assign rb      = {rd_round, 2'b00};
    assign rd_comb = (valid_q && rd_round <= nr_q) ?
                     {buf_q[rb], buf_q[rb + 6'd1], buf_q[rb + 6'd2], buf_q[rb + 6'd3]} : '0;

    if (RD_REG) begin : g_rd_reg
        logic [127:0] rd_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) rd_q <= '0;
            else        rd_q <= rd_comb;
        end
        assign rd_key = rd_q;
    end else begin : g_rd_comb
        assign rd_key = rd_comb;
    end

    assign busy       = (state_q == EXPAND);
    assign done       = done_q;
    assign err        = err_q;
    assign key_valid  = valid_q;
    assign num_rounds = nr_q;

endmodule

// File: tb/tb_key_expand_iter.sv
// tb_key_expand_iter: scoreboard bench for key_expand_iter using FIPS-197 key vectors,
// with a second instance built with SUPPORT_256=0 and a combinational read port.
module tb_key_expand_iter;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic start = 1'b0, start0 = 1'b0;
    logic [1:0] mode = 2'b00, mode0 = 2'b00;
    logic [255:0] key_in = '0, key0 = '0;
    logic [3:0] rd_round = '0, rd_round0 = '0, rd_round_d = '0;
    logic busy, done, err, key_valid, busy0, done0, err0, key_valid0;
    logic [3:0] num_rounds, num_rounds0;
    logic [127:0] rd_key, rd_key0;
    logic rd_req = 1'b0, rd_req_d = 1'b0, rd_req0 = 1'b0, stat_req = 1'b0, stat_req0 = 1'b0;

    int checks = 0, errors = 0, bcnt = 0, bcnt0 = 0;
    logic [127:0] q_done[$], q_err[$], q_stat[$], q_rd[$];
    logic [127:0] q_done0[$], q_err0[$], q_stat0[$], q_rd0[$];
    logic [7:0] st, st0;

    always #5 clk = ~clk;

    key_expand_iter #(.SUPPORT_256(1'b1), .RD_REG(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .key_in(key_in),
        .busy(busy), .done(done), .err(err), .key_valid(key_valid),
        .num_rounds(num_rounds), .rd_round(rd_round), .rd_key(rd_key)
    );

    key_expand_iter #(.SUPPORT_256(1'b0), .RD_REG(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .mode(mode0), .key_in(key0),
        .busy(busy0), .done(done0), .err(err0), .key_valid(key_valid0),
        .num_rounds(num_rounds0), .rd_round(rd_round0), .rd_key(rd_key0)
    );

    assign st  = {busy, done, err, key_valid, num_rounds};
    assign st0 = {busy0, done0, err0, key_valid0, num_rounds0};

    function automatic void chk(input string n, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endfunction

    always @(posedge clk) begin
        rd_req_d   <= rd_req;
        rd_round_d <= rd_round;
    end

    // Monitor: pops an expectation whenever a DUT presents an event
    always @(negedge clk) begin
        if (done || err) chk("done_err_excl", 128'(done && err), 0);
        if (done) begin
            if (q_done.size() == 0) chk("unexpected_done", 128'(done), 0);
            else chk("done_latency", 128'(bcnt), q_done.pop_front());
            bcnt = 0;
        end
        if (err) begin
            if (q_err.size() == 0) chk("unexpected_err", 128'(err), 0);
            else chk("err_status", 128'(st), q_err.pop_front());
        end
        if (stat_req) chk("status", 128'(st), q_stat.pop_front());
        if (rd_req_d) chk($sformatf("rd_key_r%0d", rd_round_d), rd_key, q_rd.pop_front());
        bcnt = !rst_n ? 0 : bcnt + int'(busy);
        if (done0 || err0) chk("done_err_excl0", 128'(done0 && err0), 0);
        if (done0) begin
            if (q_done0.size() == 0) chk("unexpected_done0", 128'(done0), 0);
            else chk("done_latency0", 128'(bcnt0), q_done0.pop_front());
            bcnt0 = 0;
        end
        if (err0) begin
            if (q_err0.size() == 0) chk("unexpected_err0", 128'(err0), 0);
            else chk("err_status0", 128'(st0), q_err0.pop_front());
        end
        if (stat_req0) chk("status0", 128'(st0), q_stat0.pop_front());
        if (rd_req0) chk($sformatf("rd_key0_r%0d", rd_round0), rd_key0, q_rd0.pop_front());
        bcnt0 = !rst_n ? 0 : bcnt0 + int'(busy0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input bit sel, input logic [1:0] m, input logic [255:0] k, input int lat);
        if (sel) begin
            mode0 = m; key0 = k; start0 = 1'b1; q_done0.push_back(128'(lat));
        end else begin
            mode = m; key_in = k; start = 1'b1; q_done.push_back(128'(lat));
        end
        tick();
        start = 1'b0;
        start0 = 1'b0;
        repeat (lat + 2) tick();
    endtask

    task automatic rd(input bit sel, input logic [3:0] r, input logic [127:0] e);
        if (sel) begin
            rd_round0 = r; rd_req0 = 1'b1; q_rd0.push_back(e);
        end else begin
            rd_round = r; rd_req = 1'b1; q_rd.push_back(e);
        end
        tick();
        rd_req = 1'b0;
        rd_req0 = 1'b0;
    endtask

    task automatic stat(input bit sel, input logic [7:0] e);
        if (sel) begin stat_req0 = 1'b1; q_stat0.push_back(128'(e)); end
        else begin stat_req = 1'b1; q_stat.push_back(128'(e)); end
        tick();
        stat_req = 1'b0;
        stat_req0 = 1'b0;
    endtask

    task automatic bad_start(input bit sel, input logic [1:0] m, input logic [255:0] k);
        if (sel) begin mode0 = m; key0 = k; start0 = 1'b1; q_err0.push_back(128'(8'h3A)); end
        else begin mode = m; key_in = k; start = 1'b1; q_err.push_back(128'(8'h3A)); end
        tick();
        start = 1'b0;
        start0 = 1'b0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        stat(0, 8'h00);
        rd(0, 4'd0, '0);
        rst_n = 1'b1;
        tick();
        // AES-128
        run(0, 2'b00, K128, 40);
        rd(0, 4'd0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        rd(0, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
        rd(0, 4'd2, 128'hf2c295f27a96b9435935807a7359f67f);
        rd(0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd(0, 4'd11, '0);
        stat(0, 8'h1A);
        // Reserved mode after a completed schedule
        bad_start(0, 2'b11, K256);
        stat(0, 8'h1A);
        rd(0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        // Restart attempt mid-expansion must be ignored
        mode = 2'b00; key_in = K128; start = 1'b1; q_done.push_back(128'd40);
        tick();
        start = 1'b0;
        repeat (10) tick();
        mode = 2'b01; key_in = K192; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (32) tick();
        rd(0, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        stat(0, 8'h1A);
        // AES-192
        run(0, 2'b01, K192, 46);
        rd(0, 4'd0, 128'h8e73b0f7da0e6452c810f32b809079e5);
        rd(0, 4'd1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        rd(0, 4'd12, 128'he98ba06f448c773c8ecc720401002202);
        rd(0, 4'd13, '0);
        stat(0, 8'h1C);
        // AES-256
        run(0, 2'b10, K256, 52);
        rd(0, 4'd0, 128'h603deb1015ca71be2b73aef0857d7781);
        rd(0, 4'd1, 128'h1f352c073b6108d72d9810a30914dff4);
        rd(0, 4'd2, 128'h9ba354118e6925afa51a8b5f2067fcde);
        rd(0, 4'd3, 128'ha8b09c1a93d194cdbe49846eb75d5b9a);
        rd(0, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e);
        rd(0, 4'd15, '0);
        stat(0, 8'h1E);
        // Reset at cycle 20 of an AES-128 expansion
        mode = 2'b00; key_in = K128; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        rst_n = 1'b0;
        stat(0, 8'h00);
        rd(0, 4'd10, '0);
        rst_n = 1'b1;
        repeat (40) tick();
        stat(0, 8'h00);
        rd(0, 4'd0, '0);
        // Instance without AES-256 and with a combinational read port
        run(1, 2'b00, K128, 40);
        rd(1, 4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
        rd(1, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        bad_start(1, 2'b10, K256);
        stat(1, 8'h1A);
        rd(1, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd(1, 4'd11, '0);
        repeat (3) tick();
        chk("leftover_done", 128'(q_done.size() + q_done0.size()), 0);
        chk("leftover_err", 128'(q_err.size() + q_err0.size()), 0);
        chk("leftover_rd", 128'(q_rd.size() + q_rd0.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_expand_iter.md
KEY_EXPAND_ITER -- requirements
Module: key_expand_iter

Interface
REQ-001 SHALL have parameter SUPPORT_256, default 1, meaning AES-256 mode is enabled; when 0, mode 2'b10 is treated as reserved.
REQ-002 SHALL have parameter RD_REG, default 1, meaning rd_key is registered (1-cycle read latency); when 0, rd_key is combinational.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  request expansion of key_in in mode; sampled only while idle.
REQ-006 mode  in  2  00=AES-128 (Nk=4,Nr=10), 01=AES-192 (Nk=6,Nr=12), 10=AES-256 (Nk=8,Nr=14), 11=reserved.
REQ-007 key_in  in  256  cipher key, MSB-aligned; 128-bit key in [255:128], 192-bit key in [255:64], w[0] always in [255:224].
REQ-008 busy  out  1  expansion in progress.
REQ-009 done  out  1  one-cycle pulse when the schedule is complete.
REQ-010 err  out  1  one-cycle pulse when start is sampled with a reserved/disabled mode.
REQ-011 key_valid  out  1  the stored schedule is complete and readable.
REQ-012 num_rounds  out  4  Nr of the stored schedule (10/12/14); 0 after reset.
REQ-013 rd_round  in  4  round-key index to read, 0..Nr.
REQ-014 rd_key  out  128  round key rd_round: {w[4r],w[4r+1],w[4r+2],w[4r+3]}, w[4r] in [127:96].

Function
REQ-015 SHALL use an FSM with states IDLE and EXPAND; IDLE->EXPAND on start with a valid mode; EXPAND->IDLE after writing the last word.
REQ-016 When start is accepted, key_in words w[0..Nk-1] SHALL be written to the 60x32 word buffer, Nk/Nr latched, word index i set to Nk, key_valid cleared, and busy set, all on the same edge.
REQ-017 In EXPAND, exactly one word SHALL be produced per cycle: w[i] = w[i-Nk] ^ t, with t = w[i-1].
REQ-018 If i mod Nk == 0, t SHALL be SubWord(RotWord(w[i-1])) ^ {Rcon[i/Nk],24'h0}.
REQ-019 If Nk == 8 and i mod 8 == 4, t SHALL be SubWord(w[i-1]) with no rotation and no Rcon.
REQ-020 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1b,36.
REQ-021 The last word index SHALL be 4*(Nr+1)-1 (43/51/59), so EXPAND lasts 40/46/52 cycles for modes 00/01/10.
REQ-022 On the edge that writes the last word, busy SHALL clear, key_valid SHALL set, and done SHALL be high for exactly the following cycle.
REQ-023 start SHALL be ignored while busy; there SHALL be no restart and no err.
REQ-024 start with mode 11, or mode 10 when SUPPORT_256=0, SHALL pulse err for one cycle and SHALL leave state, buffer, key_valid and num_rounds unchanged.
REQ-025 rd_key SHALL be 128'h0 when key_valid is 0 or rd_round > num_rounds.
REQ-026 rd_key latency from rd_round SHALL be 1 cycle when RD_REG=1 and 0 cycles when RD_REG=0.
REQ-027 done and err SHALL never be asserted in the same cycle.

Reset
REQ-028 Asserting rst_n low SHALL force IDLE, with busy, done, err, key_valid and num_rounds at 0 and rd_key at 0, asynchronously.
REQ-029 Reset asserted mid-EXPAND SHALL abort the expansion; no done SHALL follow, and key_valid SHALL remain 0 until a new expansion completes.
REQ-030 Buffer contents need not be reset; key_valid gating (REQ-025) SHALL mask them.

Structure
REQ-031 A shared package key_sched_pkg SHALL hold the mode encoding, Nk/Nr lookup constants, the Rcon table and the max word count (60).
REQ-032 SubWord SHALL be built from four instances of the existing sbox sub-module, shared by the REQ-018 and REQ-019 paths.
REQ-033 i mod Nk SHALL be tracked with a separate wrapping counter (0..Nk-1) and a round counter; there SHALL be no divider.

Verification
REQ-034 Mode 00, key 2b7e151628aed2a6abf7158809cf4f3c: done 40 cycles after start; rd_round=1 -> a0fafe1788542cb123a339392a6c7605; rd_round=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-035 Mode 01, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b: done after 46 cycles; rd_round=12 -> e98ba06f448c773c8ecc720401002202; rd_round=13 -> 0.
REQ-036 Mode 10, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4: done after 52 cycles; rd_round=14 -> fe4890d1e6188d0b046df344706c631e; num_rounds=14.
REQ-037 mode=11 start after a completed AES-128 run: err single pulse, no busy, key_valid stays 1, round 10 still reads d014f9a8...; repeat with SUPPORT_256=0 and mode=10: same result.
REQ-038 start pulsed again mid-EXPAND with a different key: ignored, original schedule completes on time; separately, rst_n low at cycle 20 of EXPAND: busy=0, key_valid=0, no done, rd_key=0.
